page_dump_tx: RTL and testbench

Read-side companion to the 256×8 page parameter buffer on the VSDSquadron FM (iCE40UP5K, 12 MHz `hw_clk`). The block owns an inferred 256×8 block RAM with a host write port. On command, it reads a run of consecutive bytes back out of that RAM and serializes them as 8N1 UART frames on a single output pin, so that page contents can be dumped to a host terminal.

---
 rtl/page_dump_tx.sv | 200 ++++++++++++++++++++
 tb/tb_page_dump_tx.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/page_dump_tx.sv
// page_dump_tx: 256x8 page buffer with host write port and 8N1 UART dump of a run of bytes.
// Define PAGE_DUMP_CHECKSUM_EN to append a mod-256 sum frame after the last data byte.
module page_dump_tx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       hw_clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [7:0] start_idx,
    input  logic [8:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] cur_idx,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5,
        CSUM  = 3'd6,
        FIN   = 3'd7
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [256];
    logic [7:0]      rd_data;
    logic [7:0]      rd_ptr, rd_ptr_n;
    logic [8:0]      remaining, remaining_n;
    logic [7:0]      shifter, shifter_n;
    logic [CW-1:0]   clk_cnt, clk_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic            tx_n, busy_n, done_n;
    logic            bit_done;
`ifdef PAGE_DUMP_CHECKSUM_EN
    logic [7:0]      csum, csum_n;
    logic            csum_frame, csum_frame_n;
`endif

    // Registered read gives the 1-cycle RAM latency; same-address write returns old data.
    always_ff @(posedge hw_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (state == FETCH) begin
            rd_data <= mem[rd_ptr];
        end
    end

    assign bit_done = (clk_cnt == LAST_CLK);
    assign cur_idx  = rd_ptr;

    always_ff @(posedge hw_clk) begin
        if (rst) begin
            state      <= IDLE;
            rd_ptr     <= 8'd0;
            remaining  <= 9'd0;
            shifter    <= 8'd0;
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef PAGE_DUMP_CHECKSUM_EN
            csum       <= 8'd0;
            csum_frame <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            rd_ptr     <= rd_ptr_n;
            remaining  <= remaining_n;
            shifter    <= shifter_n;
            clk_cnt    <= clk_cnt_n;
            bit_idx    <= bit_idx_n;
            tx         <= tx_n;
            busy       <= busy_n;
            done       <= done_n;
`ifdef PAGE_DUMP_CHECKSUM_EN
            csum       <= csum_n;
            csum_frame <= csum_frame_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        rd_ptr_n     = rd_ptr;
        remaining_n  = remaining;
        shifter_n    = shifter;
        clk_cnt_n    = clk_cnt;
        bit_idx_n    = bit_idx;
        tx_n         = tx;
        busy_n       = busy;
        done_n       = 1'b0;
`ifdef PAGE_DUMP_CHECKSUM_EN
        csum_n       = csum;
        csum_frame_n = csum_frame;
`endif
        case (state)
            IDLE: begin
                // The done cycle is still IDLE; a start landing on it is dropped.
                if (start && !done) begin
                    rd_ptr_n    = start_idx;
                    remaining_n = len;
                    busy_n      = 1'b1;
`ifdef PAGE_DUMP_CHECKSUM_EN
                    csum_n       = 8'd0;
                    csum_frame_n = 1'b0;
`endif
                    state_n = (len != 9'd0) ? FETCH : FIN;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                shifter_n = rd_data;
`ifdef PAGE_DUMP_CHECKSUM_EN
                csum_n    = csum + rd_data;
`endif
                tx_n      = 1'b0;
                clk_cnt_n = '0;
                state_n   = START;
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_n = '0;
                    tx_n      = shifter[0];
                    shifter_n = {1'b0, shifter[7:1]};
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        tx_n      = shifter[0];
                        shifter_n = {1'b0, shifter[7:1]};
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_n = '0;
`ifdef PAGE_DUMP_CHECKSUM_EN
                    if (csum_frame) begin
                        state_n = FIN;
                    end else begin
                        rd_ptr_n    = rd_ptr + 8'd1;
                        remaining_n = remaining - 9'd1;
                        state_n     = (remaining != 9'd1) ? FETCH : CSUM;
                    end
`else
                    rd_ptr_n    = rd_ptr + 8'd1;
                    remaining_n = remaining - 9'd1;
                    state_n     = (remaining != 9'd1) ? FETCH : FIN;
`endif
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
`ifdef PAGE_DUMP_CHECKSUM_EN
            CSUM: begin
                shifter_n    = csum;
                csum_frame_n = 1'b1;
                tx_n         = 1'b0;
                clk_cnt_n    = '0;
                state_n      = START;
            end
`endif
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_page_dump_tx.sv
// Directed bench for page_dump_tx at CLKS_PER_BIT=4: decodes tx frames per cycle and checks bytes/timing.
module tb_page_dump_tx;

    localparam int CPB = 4;

    logic       hw_clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic [7:0] start_idx = 8'd0;
    logic [8:0] len = 9'd0;
    logic       busy;
    logic       done;
    logic [7:0] cur_idx;
    logic       tx;

    int n_checks = 0;
    int n_fail = 0;

    logic       tx_log[$];
    logic [7:0] idx_log[$];
    logic [7:0] got_q[$];
    int         start_q[$];
    logic [7:0] exp_q[$];
    int         busy_cycles;
    int         done_pulses;
    int         done_at;

    page_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
        .hw_clk(hw_clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_idx(start_idx), .len(len),
        .busy(busy), .done(done), .cur_idx(cur_idx), .tx(tx)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge hw_clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge hw_clk);
        wr_en = 1'b0;
    endtask

    // mode: 0 plain, 1 start pulse mid-dump, 2 start on the done cycle, 3 write 0xAA@0x42 mid-dump
    task automatic run_dump(input logic [7:0] idx, input logic [8:0] n, input int mode);
        tx_log.delete(); idx_log.delete();
        busy_cycles = 0; done_pulses = 0; done_at = -1;
        @(negedge hw_clk);
        start = 1'b1; start_idx = idx; len = n;
        @(negedge hw_clk);
        for (int c = 0; c < 600; c++) begin
            tx_log.push_back(tx);
            idx_log.push_back(cur_idx);
            if (busy === 1'b1) busy_cycles++;
            if (done === 1'b1) begin
                done_pulses++;
                if (done_at < 0) done_at = c;
            end
            start = 1'b0; wr_en = 1'b0;
            if (mode == 1 && c == 20) begin start = 1'b1; len = 9'd5; end
            if (mode == 2 && done === 1'b1) start = 1'b1;
            if (mode == 3 && c == 10) begin wr_en = 1'b1; wr_addr = 8'h42; wr_data = 8'hAA; end
            if (done_at >= 0 && c >= done_at + 3) break;
            @(negedge hw_clk);
        end
        start = 1'b0; wr_en = 1'b0;
        n_checks++;
        if (done_at < 0) begin
            n_fail++;
            $display("FAIL dump_timeout: done=never, required done within 600 cycles");
        end
    endtask

    // Frame extraction from the per-cycle tx log: a low sample marks the first start-bit cycle.
    task automatic decode();
        int k;
        logic [7:0] b;
        got_q.delete(); start_q.delete();
        k = 0;
        while (k < tx_log.size()) begin
            if (tx_log[k] === 1'b0 && k + 4 * 9 + 2 < tx_log.size()) begin
                for (int i = 0; i < 8; i++) b[i] = tx_log[k + CPB * (i + 1) + 2];
                got_q.push_back(b);
                start_q.push_back(k);
                k += 10 * CPB;
            end else begin
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge hw_clk);
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++;
        if (cur_idx !== 8'h00) begin n_fail++; $display("FAIL reset_cur_idx: got %h, required 00", cur_idx); end
        rst = 1'b0;
    endtask

    task automatic test_single_byte();
        int exp_busy;
        write_byte(8'h03, 8'h0E);
        run_dump(8'h03, 9'd1, 0);
        decode();
        exp_q = {8'h0E};
        exp_busy = 43;
`ifdef PAGE_DUMP_CHECKSUM_EN
        exp_q.push_back(8'h0E);
        exp_busy = 84;
`endif
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL single_frames: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
            n_checks++;
            if (start_q[0] !== 2) begin n_fail++; $display("FAIL single_tx_fall: got cycle %0d, required 2", start_q[0]); end
            n_checks++;
            if (tx_log[start_q[0] + 38] !== 1'b1 || tx_log[start_q[0] + 3] !== 1'b0) begin
                n_fail++; $display("FAIL single_start_stop: got start=%b stop=%b, required 0 and 1", tx_log[start_q[0] + 3], tx_log[start_q[0] + 38]);
            end
        end
        n_checks++;
        if (busy_cycles !== exp_busy) begin n_fail++; $display("FAIL single_busy_len: got %0d, required %0d", busy_cycles, exp_busy); end
        n_checks++;
        if (done_pulses !== 1) begin n_fail++; $display("FAIL single_done_pulses: got %0d, required 1", done_pulses); end
        n_checks++;
        if (done_at !== exp_busy) begin n_fail++; $display("FAIL single_done_cycle: got %0d, required %0d", done_at, exp_busy); end
    endtask

    task automatic test_wrap();
        write_byte(8'hFF, 8'h11);
        write_byte(8'h00, 8'h22);
        run_dump(8'hFF, 9'd2, 0);
        decode();
        exp_q = {8'h11, 8'h22};
`ifdef PAGE_DUMP_CHECKSUM_EN
        exp_q.push_back(8'h33);
`endif
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wrap_frames: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
            n_checks++;
            if (idx_log[0] !== 8'hFF) begin n_fail++; $display("FAIL wrap_idx_first: got %h, required ff", idx_log[0]); end
            n_checks++;
            if (idx_log[start_q[1]] !== 8'h00) begin n_fail++; $display("FAIL wrap_idx_second: got %h, required 00", idx_log[start_q[1]]); end
            n_checks++;
            if (start_q[1] - start_q[0] !== 10 * CPB + 2) begin
                n_fail++; $display("FAIL wrap_gap: got %0d, required %0d", start_q[1] - start_q[0], 10 * CPB + 2);
            end
        end
    endtask

    task automatic test_checksum();
        write_byte(8'h10, 8'hF0);
        write_byte(8'h11, 8'h20);
        // mid-dump start pulse with a different len must not change the byte count
        run_dump(8'h10, 9'd2, 1);
        decode();
        exp_q = {8'hF0, 8'h20};
`ifdef PAGE_DUMP_CHECKSUM_EN
        exp_q.push_back(8'h10);
`endif
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL csum_frames: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL csum_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
`ifdef PAGE_DUMP_CHECKSUM_EN
            n_checks++;
            if (start_q[2] - start_q[1] !== 10 * CPB + 1) begin
                n_fail++; $display("FAIL csum_gap: got %0d, required %0d", start_q[2] - start_q[1], 10 * CPB + 1);
            end
`endif
        end
        n_checks++;
        if (done_pulses !== 1) begin n_fail++; $display("FAIL csum_done_pulses: got %0d, required 1", done_pulses); end
    endtask

    task automatic test_zero_len();
        int zeros;
        // start held on the done cycle must be ignored
        run_dump(8'h20, 9'd0, 2);
        zeros = 0;
        foreach (tx_log[i]) if (tx_log[i] !== 1'b1) zeros++;
        n_checks++;
        if (zeros !== 0) begin n_fail++; $display("FAIL zero_tx_low: got %0d low cycles, required 0", zeros); end
        n_checks++;
        if (done_at !== 1) begin n_fail++; $display("FAIL zero_done_cycle: got %0d, required 1", done_at); end
        n_checks++;
        if (busy_cycles !== 1) begin n_fail++; $display("FAIL zero_busy_len: got %0d, required 1", busy_cycles); end
        n_checks++;
        if (done_pulses !== 1) begin n_fail++; $display("FAIL zero_done_pulses: got %0d, required 1", done_pulses); end
    endtask

    task automatic test_write_during_dump();
        write_byte(8'h40, 8'h5A);
        write_byte(8'h41, 8'hC3);
        write_byte(8'h42, 8'h00);
        run_dump(8'h40, 9'd3, 3);
        decode();
        exp_q = {8'h5A, 8'hC3, 8'hAA};
`ifdef PAGE_DUMP_CHECKSUM_EN
        exp_q.push_back(8'hC7);
`endif
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wdd_frames: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wdd_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        int dones;
        @(negedge hw_clk);
        start = 1'b1; start_idx = 8'h40; len = 9'd3;
        @(negedge hw_clk);
        start = 1'b0;
        repeat (19) @(negedge hw_clk);   // inside data bit 3 of byte 0
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rmf_busy_before: got %b, required 1", busy); end
        rst = 1'b1;
        @(negedge hw_clk);
        rst = 1'b0;
        n_checks++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL rmf_tx: got %b, required 1", tx); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmf_busy: got %b, required 0", busy); end
        lows = 0; dones = 0;
        for (int c = 0; c < 60; c++) begin
            if (tx !== 1'b1) lows++;
            if (done !== 1'b0) dones++;
            @(negedge hw_clk);
        end
        n_checks++;
        if (dones !== 0) begin n_fail++; $display("FAIL rmf_no_done: got %0d done cycles, required 0", dones); end
        n_checks++;
        if (lows !== 0) begin n_fail++; $display("FAIL rmf_tx_idle: got %0d low cycles, required 0", lows); end
        run_dump(8'h40, 9'd3, 0);
        decode();
        exp_q = {8'h5A, 8'hC3, 8'hAA};
`ifdef PAGE_DUMP_CHECKSUM_EN
        exp_q.push_back(8'hC7);
`endif
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rmf_frames: got %0d, required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rmf_byte%0d: got %h, required %h", i, got_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_wrap();
        test_checksum();
        test_zero_len();
        test_write_during_dump();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
